// File: rtl/pucch_seq_pkg.sv
// Shared constants for the PUCCH low-PAPR sequence rotator: phi table,
// phase LUT (units of 15 deg, mod 24), sequence length and FSM states.
package pucch_seq_pkg;

    localparam int N_SC   = 12;
    localparam int PH_MOD = 24;
    localparam int U_NUM  = 30;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } st_e;

    // phi_u(n) codes: phi = 2*code - 3
    localparam logic [1:0] M3 = 2'd0;
    localparam logic [1:0] M1 = 2'd1;
    localparam logic [1:0] P1 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    // Row u packs n = 0 in the top two bits down to n = 11 in the bottom two.
    localparam logic [23:0] PHI_TAB [U_NUM] = '{
        {M3, P1, M3, M3, M3, P3, M3, M1, P1, P1, P1, M3},
        {M3, P3, P1, M3, P1, P3, M1, M1, P1, P3, P3, P3},
        {M3, P3, P3, P1, M3, P3, M1, P1, P3, M3, P3, M3},
        {M3, M3, M1, P3, P3, P3, M3, P3, M3, P1, M1, M3},
        {M3, M1, M1, P1, P3, P1, P1, M1, P1, M1, M3, P1},
        {M3, M3, P3, P1, M3, M3, M3, M1, P3, M1, P1, P3},
        {P1, M1, P3, M1, M1, M1, M3, M1, P1, P1, P1, M3},
        {M1, M3, P3, M1, M3, M3, M3, M1, P1, M1, P1, M3},
        {M3, M1, P3, P1, M3, M1, M3, P3, P1, P3, P3, P1},
        {M3, M1, M1, M3, M3, M1, M3, P3, M1, P3, M1, M3},
        {M3, P3, M3, P3, P3, M3, M1, M1, P3, P3, P1, M3},
        {M3, M1, M3, M1, M1, M3, P3, P3, M1, M1, P1, M3},
        {M3, M1, P3, M3, M3, M1, M3, P1, M1, M3, P3, P3},
        {M3, P1, M1, M1, P3, P3, M3, M1, M1, M3, M1, M3},
        {P1, P3, M3, P1, P3, P3, P3, P1, M1, P1, M1, P3},
        {M3, P1, P3, M1, M1, M3, M3, M1, M1, P3, P1, M3},
        {M1, M1, M1, M1, P1, M3, M1, P3, P3, M1, M3, P1},
        {M1, P1, P1, M1, P1, P3, P3, M1, M1, M3, P1, M3},
        {M3, P1, P3, P3, M1, M1, M3, P3, P3, M3, P3, M3},
        {M3, M3, P3, M3, M1, P3, P3, P3, M1, M3, P1, M3},
        {P3, P1, P3, P1, P3, M3, M1, P1, P3, P1, M1, M3},
        {M3, P3, P1, P3, M3, P1, P1, P1, P1, P3, M3, P3},
        {M3, P3, P3, P3, M1, M3, M3, M1, M3, P1, P3, M3},
        {P3, M1, M3, P3, M3, M1, P3, P3, P3, M3, M1, M3},
        {M3, M1, P1, M3, P1, P3, P3, P3, M1, M3, P3, P3},
        {M3, P3, P1, M1, P3, P3, M3, P1, M1, P1, M1, P1},
        {M1, P1, P3, M3, P1, M1, P1, M1, M1, M3, P1, M1},
        {M3, M3, P3, P3, P3, M3, M1, P1, M3, P3, P1, M3},
        {P1, M1, P3, P1, P1, M1, M1, M1, P1, P3, M3, P1},
        {M3, P3, M3, P3, M3, M3, P3, M1, M1, P1, P3, M3}
    };

    // round(32767 * cos(p * 15 deg)); sin(p) reads entry (p - 6) mod 24.
    localparam logic signed [15:0] COS_LUT [PH_MOD] = '{
         16'sd32767,  16'sd31650,  16'sd28377,  16'sd23170,
         16'sd16384,  16'sd8481,   16'sd0,     -16'sd8481,
        -16'sd16384, -16'sd23170, -16'sd28377, -16'sd31650,
        -16'sd32767, -16'sd31650, -16'sd28377, -16'sd23170,
        -16'sd16384, -16'sd8481,   16'sd0,      16'sd8481,
         16'sd16384,  16'sd23170,  16'sd28377,  16'sd31650
    };

    function automatic logic [1:0] phi_code(input logic [4:0] u,
                                            input logic [3:0] n);
        logic [23:0] row;
        int sh;
        row = PHI_TAB[u];
        sh  = 2 * (N_SC - 1 - int'(n));
        return row[sh +: 2];
    endfunction

    // 3*phi mod 24
    function automatic logic [4:0] phi_term(input logic [1:0] code);
        logic [4:0] t;
        t = 5'd0;
        unique case (code)
            M3: t = 5'd15;
            M1: t = 5'd21;
            P1: t = 5'd3;
            P3: t = 5'd9;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pucch_phase_lut.sv
// Combinational phase-to-I/Q lookup; phase in 15 deg steps (0..23).
module pucch_phase_lut
    import pucch_seq_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic [4:0]              phase_i,
    output logic signed [OUT_W-1:0] re_o,
    output logic signed [OUT_W-1:0] im_o
);

    logic [4:0]        sin_idx;
    logic signed [15:0] c;
    logic signed [15:0] s;

    always_comb begin
        sin_idx = (phase_i < 5'd6) ? phase_i + 5'd18 : phase_i - 5'd6;
        c       = COS_LUT[phase_i];
        s       = COS_LUT[sin_idx];
    end

    generate
        if (OUT_W >= 16) begin : g_wide
            assign re_o = OUT_W'(c) <<< (OUT_W - 16);
            assign im_o = OUT_W'(s) <<< (OUT_W - 16);
        end else begin : g_narrow
            assign re_o = OUT_W'(c >>> (16 - OUT_W));
            assign im_o = OUT_W'(s >>> (16 - OUT_W));
        end
    endgenerate

endmodule

// File: rtl/pucch_lowpapr_seq_rotator.sv
// Serial emitter of cyclically shifted length-12 low-PAPR sequences.
// Define PUCCH_SEQ_B2B_EN to accept the next alpha on the n = 11 beat.
module pucch_lowpapr_seq_rotator
    import pucch_seq_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int N_SC  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              i_u,
    input  logic [4:0]              i_alpha,
    input  logic                    i_alpha_valid,
    output logic                    o_alpha_ready,
    output logic signed [OUT_W-1:0] o_re,
    output logic signed [OUT_W-1:0] o_im,
    output logic [3:0]              o_sc_idx,
    output logic                    o_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_err
);

    localparam logic [3:0] N_LAST = 4'(N_SC - 1);
    localparam logic [5:0] MOD6   = 6'(PH_MOD);

    st_e                     state_q, state_d;
    logic [4:0]              u_q, u_d;
    logic [3:0]              alpha_q, alpha_d;
    logic [3:0]              n_q, n_d;
    logic [4:0]              acc_q, acc_d;
    logic                    err_q, err_d;
    logic signed [OUT_W-1:0] re_q, im_q, re_d, im_d;

    logic       accept, fire, at_last;
    logic [4:0] u_red, a_tmp;
    logic [3:0] a_red;
    logic [5:0] acc_sum, ph_sum;
    logic [4:0] ph_d;

    assign o_valid = (state_q == ST_RUN);
    assign at_last = (n_q == N_LAST);
    assign fire    = o_valid & i_ready;
    assign accept  = i_alpha_valid & o_alpha_ready;

`ifdef PUCCH_SEQ_B2B_EN
    assign o_alpha_ready = (state_q == ST_IDLE) | (fire & at_last);
`else
    assign o_alpha_ready = (state_q == ST_IDLE);
`endif

    always_comb begin
        u_red = (i_u >= 5'd30) ? i_u - 5'd30 : i_u;
        a_tmp = i_alpha;
        if (a_tmp >= 5'd12) a_tmp = a_tmp - 5'd12;
        if (a_tmp >= 5'd12) a_tmp = a_tmp - 5'd12;
        a_red = 4'(a_tmp);
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        alpha_d = alpha_q;
        n_d     = n_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        acc_sum = 6'(acc_q) + 6'({alpha_q, 1'b0});
        if (fire) begin
            if (at_last) begin
                state_d = ST_IDLE;
                n_d     = '0;
                acc_d   = '0;
            end else begin
                n_d   = n_q + 4'd1;
                acc_d = (acc_sum >= MOD6) ? 5'(acc_sum - MOD6)
                                          : 5'(acc_sum);
            end
        end
        if (accept) begin
            state_d = ST_RUN;
            u_d     = u_red;
            alpha_d = a_red;
            n_d     = '0;
            acc_d   = '0;
            err_d   = (i_alpha >= 5'd12);
        end
        // Phase of the sample that will be on the outputs next cycle
        ph_sum = 6'(acc_d) + 6'(phi_term(phi_code(u_d, n_d)));
        ph_d   = (ph_sum >= MOD6) ? 5'(ph_sum - MOD6) : 5'(ph_sum);
    end

    pucch_phase_lut #(
        .OUT_W (OUT_W)
    ) u_lut (
        .phase_i (ph_d),
        .re_o    (re_d),
        .im_o    (im_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            u_q     <= '0;
            alpha_q <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            alpha_q <= alpha_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign o_re     = re_q;
    assign o_im     = im_q;
    assign o_sc_idx = n_q;
    assign o_last   = at_last & o_valid;
    assign o_err    = err_q;

endmodule

// File: tb/tb_pucch_lowpapr_seq_rotator.sv
// Bench for pucch_lowpapr_seq_rotator: vector table, trigonometric
// reference model, stalls, reset abort and back-to-back sequences.
module tb_pucch_lowpapr_seq_rotator;

    localparam int  OUT_W = 16;
    localparam real PI    = 3.14159265358979323846;
`ifdef PUCCH_SEQ_B2B_EN
    localparam int EXP_BUB = 0;
`else
    localparam int EXP_BUB = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [4:0]              i_u;
    logic [4:0]              i_alpha;
    logic                    i_alpha_valid;
    logic                    o_alpha_ready;
    logic signed [OUT_W-1:0] o_re;
    logic signed [OUT_W-1:0] o_im;
    logic [3:0]              o_sc_idx;
    logic                    o_last;
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_err;

    always #5 clk = ~clk;

    pucch_lowpapr_seq_rotator #(
        .OUT_W (OUT_W),
        .N_SC  (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_u           (i_u),
        .i_alpha       (i_alpha),
        .i_alpha_valid (i_alpha_valid),
        .o_alpha_ready (o_alpha_ready),
        .o_re          (o_re),
        .o_im          (o_im),
        .o_sc_idx      (o_sc_idx),
        .o_last        (o_last),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_err         (o_err)
    );

    int checks = 0;
    int errors = 0;

    int PHI_T [30][12] = '{
        '{-3, 1,-3,-3,-3, 3,-3,-1, 1, 1, 1,-3},
        '{-3, 3, 1,-3, 1, 3,-1,-1, 1, 3, 3, 3},
        '{-3, 3, 3, 1,-3, 3,-1, 1, 3,-3, 3,-3},
        '{-3,-3,-1, 3, 3, 3,-3, 3,-3, 1,-1,-3},
        '{-3,-1,-1, 1, 3, 1, 1,-1, 1,-1,-3, 1},
        '{-3,-3, 3, 1,-3,-3,-3,-1, 3,-1, 1, 3},
        '{ 1,-1, 3,-1,-1,-1,-3,-1, 1, 1, 1,-3},
        '{-1,-3, 3,-1,-3,-3,-3,-1, 1,-1, 1,-3},
        '{-3,-1, 3, 1,-3,-1,-3, 3, 1, 3, 3, 1},
        '{-3,-1,-1,-3,-3,-1,-3, 3,-1, 3,-1,-3},
        '{-3, 3,-3, 3, 3,-3,-1,-1, 3, 3, 1,-3},
        '{-3,-1,-3,-1,-1,-3, 3, 3,-1,-1, 1,-3},
        '{-3,-1, 3,-3,-3,-1,-3, 1,-1,-3, 3, 3},
        '{-3, 1,-1,-1, 3, 3,-3,-1,-1,-3,-1,-3},
        '{ 1, 3,-3, 1, 3, 3, 3, 1,-1, 1,-1, 3},
        '{-3, 1, 3,-1,-1,-3,-3,-1,-1, 3, 1,-3},
        '{-1,-1,-1,-1, 1,-3,-1, 3, 3,-1,-3, 1},
        '{-1, 1, 1,-1, 1, 3, 3,-1,-1,-3, 1,-3},
        '{-3, 1, 3, 3,-1,-1,-3, 3, 3,-3, 3,-3},
        '{-3,-3, 3,-3,-1, 3, 3, 3,-1,-3, 1,-3},
        '{ 3, 1, 3, 1, 3,-3,-1, 1, 3, 1,-1,-3},
        '{-3, 3, 1, 3,-3, 1, 1, 1, 1, 3,-3, 3},
        '{-3, 3, 3, 3,-1,-3,-3,-1,-3, 1, 3,-3},
        '{ 3,-1,-3, 3,-3,-1, 3, 3, 3,-3,-1,-3},
        '{-3,-1, 1,-3, 1, 3, 3, 3,-1,-3, 3, 3},
        '{-3, 3, 1,-1, 3, 3,-3, 1,-1, 1,-1, 1},
        '{-1, 1, 3,-3, 1,-1, 1,-1,-1,-3, 1,-1},
        '{-3,-3, 3, 3, 3,-3,-1, 1,-3, 3, 1,-3},
        '{ 1,-1, 3, 1, 1,-1,-1,-1, 1, 3,-3, 1},
        '{-3, 3,-3, 3,-3,-3, 3,-1,-1, 1, 3,-3}
    };

    typedef struct {
        int u;
        int a;
        int n;
        int re;
        int im;
        int err;
    } vec_t;

    vec_t tbl [10];

    int cap_re [12];
    int cap_im [12];
    int sav_re [12];
    int sav_im [12];
    int cap_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // r(n) = A * exp(j*(2*pi*alpha*n/12 + phi*pi/4)), rounded half away from 0
    function automatic int model(input int u, input int a, input int n,
                                 input bit im);
        real ang;
        real x;
        int  uu;
        int  aa;
        uu  = u % 30;
        aa  = a % 12;
        ang = 2.0 * PI * aa * n / 12.0 + PHI_T[uu][n] * PI / 4.0;
        x   = 32767.0 * (im ? $sin(ang) : $cos(ang));
        if (x >= 0.0) return $rtoi($floor(x + 0.5 + 1e-6));
        return -$rtoi($floor(-x + 0.5 + 1e-6));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: random stalls, 2: 5-cycle stall at n = 4
    task automatic run_seq(input int u, input int a, input int mode);
        int n;
        int cyc;
        int hold_cnt;
        bit got;
        bit stalled;
        int hre;
        int him;
        int hidx;
        i_u           = 5'(u);
        i_alpha       = 5'(a);
        i_alpha_valid = 1'b1;
        i_ready       = 1'b1;
        got           = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            got = o_alpha_ready;
            tick();
        end
        i_alpha_valid = 1'b0;
        if (!got) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        cap_err = int'(o_err);
        chk("err_pulse", int'(o_err), int'(a >= 12));
        chk("first_valid", int'(o_valid), 1);
        n        = 0;
        cyc      = 0;
        hold_cnt = 0;
        stalled  = 1'b0;
        hre      = 0;
        him      = 0;
        hidx     = 0;
        while (n < 12 && cyc < 300) begin
            if (stalled) begin
                chk("hold_re", int'(o_re), hre);
                chk("hold_im", int'(o_im), him);
                chk("hold_idx", int'(o_sc_idx), hidx);
            end
            if (mode == 0) begin
                i_ready = 1'b1;
            end else if (mode == 1) begin
                i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_ready = !(n == 4 && hold_cnt < 5);
                if (!i_ready) hold_cnt++;
            end
            if (o_valid && i_ready) begin
                chk("sc_idx", int'(o_sc_idx), n);
                chk("re", int'(o_re), model(u, a, n, 1'b0));
                chk("im", int'(o_im), model(u, a, n, 1'b1));
                chk("last", int'(o_last), int'(n == 11));
                cap_re[n] = int'(o_re);
                cap_im[n] = int'(o_im);
                n++;
            end
            stalled = o_valid && !i_ready;
            hre     = int'(o_re);
            him     = int'(o_im);
            hidx    = int'(o_sc_idx);
            cyc++;
            tick();
        end
        if (n < 12) chk("beat_timeout", n, 12);
        if (mode == 2) chk("hold_cycles", hold_cnt, 5);
        chk("end_idle_valid", int'(o_valid), 0);
        chk("end_idle_ready", int'(o_alpha_ready), 1);
        i_ready = 1'b1;
    endtask

    initial begin
        int beats;
        int bubbles;
        int accepts;
        bit acc_now;
        int bu;
        int ba;

        tbl[0] = '{u: 0,  a: 0,  n: 0,  re: -23170, im: -23170, err: 0};
        tbl[1] = '{u: 0,  a: 0,  n: 1,  re:  23170, im:  23170, err: 0};
        tbl[2] = '{u: 0,  a: 6,  n: 1,  re: -23170, im: -23170, err: 0};
        tbl[3] = '{u: 0,  a: 6,  n: 2,  re: -23170, im: -23170, err: 0};
        tbl[4] = '{u: 0,  a: 13, n: 1,  re:   8481, im:  31650, err: 1};
        tbl[5] = '{u: 31, a: 0,  n: 0,  re: -23170, im: -23170, err: 0};
        tbl[6] = '{u: 0,  a: 3,  n: 3,  re: -23170, im:  23170, err: 0};
        tbl[7] = '{u: 2,  a: 25, n: 0,  re: -23170, im: -23170, err: 1};
        tbl[8] = '{u: 4,  a: 0,  n: 4,  re: -23170, im:  23170, err: 0};
        tbl[9] = '{u: 0,  a: 11, n: 11, re:  -8481, im: -31650, err: 0};

        rst           = 1'b1;
        i_u           = '0;
        i_alpha       = '0;
        i_alpha_valid = 1'b0;
        i_ready       = 1'b0;
        repeat (3) tick();
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_re", int'(o_re), 0);
        chk("rst_im", int'(o_im), 0);
        chk("rst_last", int'(o_last), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_idx", int'(o_sc_idx), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", int'(o_alpha_ready), 1);
        chk("post_rst_valid", int'(o_valid), 0);

        for (int i = 0; i < 10; i++) begin
            run_seq(tbl[i].u, tbl[i].a, 1);
            chk("tbl_re", cap_re[tbl[i].n], tbl[i].re);
            chk("tbl_im", cap_im[tbl[i].n], tbl[i].im);
            chk("tbl_err", cap_err, tbl[i].err);
        end

        run_seq(0, 5, 2);

        run_seq(0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            sav_re[i] = cap_re[i];
            sav_im[i] = cap_im[i];
        end
        run_seq(0, 13, 0);
        chk("alpha13_err", cap_err, 1);
        for (int i = 0; i < 12; i++) begin
            chk("alpha13_re", cap_re[i], sav_re[i]);
            chk("alpha13_im", cap_im[i], sav_im[i]);
        end

        run_seq(1, 4, 1);
        for (int i = 0; i < 12; i++) begin
            sav_re[i] = cap_re[i];
            sav_im[i] = cap_im[i];
        end
        run_seq(31, 4, 1);
        for (int i = 0; i < 12; i++) begin
            chk("u31_re", cap_re[i], sav_re[i]);
            chk("u31_im", cap_im[i], sav_im[i]);
        end

        // Reset in the middle of a sequence
        i_u           = 5'd0;
        i_alpha       = 5'd2;
        i_alpha_valid = 1'b1;
        i_ready       = 1'b1;
        tick();
        i_alpha_valid = 1'b0;
        for (int k = 0; k < 40 && o_sc_idx != 4'd7; k++) tick();
        chk("rst_mid_idx", int'(o_sc_idx), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", int'(o_valid), 0);
        chk("rst_mid_ready", int'(o_alpha_ready), 1);
        chk("rst_mid_re", int'(o_re), 0);
        chk("rst_mid_idx0", int'(o_sc_idx), 0);
        run_seq(0, 2, 0);

        // Two alphas presented back to back
        beats         = 0;
        bubbles       = 0;
        accepts       = 0;
        i_ready       = 1'b1;
        i_u           = 5'd5;
        i_alpha       = 5'd3;
        i_alpha_valid = 1'b1;
        for (int k = 0; k < 80 && beats < 24; k++) begin
            if (o_valid) begin
                bu = (beats < 12) ? 5 : 7;
                ba = (beats < 12) ? 3 : 10;
                chk("b2b_idx", int'(o_sc_idx), beats % 12);
                chk("b2b_re", int'(o_re), model(bu, ba, beats % 12, 1'b0));
                chk("b2b_im", int'(o_im), model(bu, ba, beats % 12, 1'b1));
                beats++;
            end else if (beats > 0) begin
                bubbles++;
            end
            acc_now = i_alpha_valid && o_alpha_ready;
            tick();
            if (acc_now) begin
                accepts++;
                if (accepts == 1) begin
                    i_u     = 5'd7;
                    i_alpha = 5'd10;
                end else begin
                    i_alpha_valid = 1'b0;
                end
            end
        end
        i_alpha_valid = 1'b0;
        chk("b2b_beats", beats, 24);
        chk("b2b_accepts", accepts, 2);
        chk("b2b_bubbles", bubbles, EXP_BUB);
        chk("b2b_end_valid", int'(o_valid), 0);

        for (int r = 0; r < 30; r++) begin
            run_seq(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
